uart_rx_cfg: RTL and testbench

Parametrised successor to the fixed-format UART receiver: deserialises an asynchronous serial line into DATA_WIDTH-bit words using a 16× oversampling tick from the baud-rate generator. Adds over the previous receiver:
- runtime parity mode (none/even/odd)
- one or two stop bits
- start-glitch rejection
- parity, framing and break flags
- optional majority-vote sampling

It sits between the pad-side rx line and the UART interface/FIFO logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_cfg.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_BIT    = 4'd7;
  localparam logic [3:0]  SAMPLE_CNT = 4'(OVERSAMPLE - 1);

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; both flops reset to idle-high.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// 16x-oversampled UART receiver: runtime parity, 1/2 stop bits, glitch/break detection.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at counts 13/14/15.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_WIDTH = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_tick,
  input  logic                  i_rx_data_input,
  input  logic [1:0]            i_parity_mode,
  output logic [DATA_WIDTH-1:0] o_data_byte,
  output logic                  o_parity,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_done_bit,
  output logic                  o_busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_WIDTH - 1);

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx, bits, bits_nx;
  logic                  rx_s, armed, samp;
  logic                  validate, shift_en, par_en, stop_en, finish;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit, ferr_acc, stop_hi;
  logic                  ferr_fin, stop_hi_fin, par_err;

  uart_rx_sync u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_async   (i_rx_data_input),
    .o_sync    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] VOTE_A = SAMPLE_CNT - 4'd2;
  localparam logic [3:0] VOTE_B = SAMPLE_CNT - 4'd1;
  logic s_a, s_b;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (i_tick) begin
      if (cnt == VOTE_A) s_a <= rx_s;
      if (cnt == VOTE_B) s_b <= rx_s;
    end
  end

  assign samp = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bits  <= bits_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bits_nx  = bits;
    validate = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    finish   = 1'b0;
    if (i_tick) begin
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == MID_BIT) begin
            cnt_nx  = '0;
            bits_nx = '0;
            if (!rx_s) begin
              state_nx = DATA;
              validate = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        DATA: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == SAMPLE_CNT) begin
            shift_en = 1'b1;
            if (bits == LAST_DATA) begin
              bits_nx  = '0;
              state_nx = parity_on(mode) ? PARITY : STOP;
            end else begin
              bits_nx = bits + 4'd1;
            end
          end
        end
        PARITY: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == SAMPLE_CNT) begin
            par_en   = 1'b1;
            state_nx = STOP;
          end
        end
        STOP: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == SAMPLE_CNT) begin
            stop_en = 1'b1;
            if (bits == LAST_STOP) begin
              finish   = 1'b1;
              bits_nx  = '0;
              state_nx = IDLE;
            end else begin
              bits_nx = bits + 4'd1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // The final stop sample is folded in combinationally so results publish on the same edge.
  assign ferr_fin    = ferr_acc | ~samp;
  assign stop_hi_fin = stop_hi | samp;
  assign par_err     = parity_on(mode) & ((^shreg) ^ par_bit ^ (mode == PAR_ODD));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      armed        <= 1'b1;
      mode         <= PAR_NONE;
      shreg        <= '0;
      par_bit      <= 1'b0;
      ferr_acc     <= 1'b0;
      stop_hi      <= 1'b0;
      o_data_byte  <= '0;
      o_parity     <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_done_bit   <= 1'b0;
    end else begin
      if (finish && ferr_fin)  armed <= 1'b0;
      else if (i_tick && rx_s) armed <= 1'b1;
      o_done_bit <= finish;
      if (validate) begin
        mode     <= i_parity_mode;
        par_bit  <= 1'b0;
        ferr_acc <= 1'b0;
        stop_hi  <= 1'b0;
      end
      if (shift_en) shreg   <= {samp, shreg[DATA_WIDTH-1:1]};
      if (par_en)   par_bit <= samp;
      if (stop_en) begin
        ferr_acc <= ferr_fin;
        stop_hi  <= stop_hi_fin;
      end
      if (finish) begin
        o_data_byte  <= shreg;
        o_parity     <= par_bit;
        o_parity_err <= par_err;
        o_frame_err  <= ferr_fin;
        o_break      <= ferr_fin & ~stop_hi_fin & ~(|shreg) & ~par_bit;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frame-level model predicts each completed word; every cycle the
// registered results must equal the last prediction, and each done pulse consumes one prediction.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [1:0] mode = 2'b01;

  logic [7:0] a_data;
  logic       a_par, a_perr, a_ferr, a_brk, a_done, a_busy;
  logic [6:0] b_data;
  logic       b_par, b_perr, b_ferr, b_brk, b_done, b_busy;

  int   n_chk = 0;
  int   n_pass = 0;
  int   dones_a = 0;
  int   dones_b = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];

  uart_rx_cfg #(.DATA_WIDTH(8), .STOP_WIDTH(1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx_data_input(rx_a),
    .i_parity_mode(mode), .o_data_byte(a_data), .o_parity(a_par), .o_parity_err(a_perr),
    .o_frame_err(a_ferr), .o_break(a_brk), .o_done_bit(a_done), .o_busy(a_busy)
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .STOP_WIDTH(2)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx_data_input(rx_b),
    .i_parity_mode(mode), .o_data_byte(b_data), .o_parity(b_par), .o_parity_err(b_perr),
    .o_frame_err(b_ferr), .o_break(b_brk), .o_done_bit(b_done), .o_busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // fb[0] is the start bit, then data LSB first, optional parity, then stop bits.
  function automatic exp_t model(input logic [15:0] fb, input int dw, input int sw,
                                 input logic [1:0] md);
    exp_t e;
    int   p;
    logic allz;
    e = '0;
    for (int i = 0; i < dw; i++) e.data[i] = fb[1+i];
    p = 1 + dw;
    if (md == 2'b01 || md == 2'b10) begin
      e.par  = fb[p];
      e.perr = (^e.data) ^ e.par ^ (md == 2'b10);
      p++;
    end
    allz = 1'b1;
    for (int i = 0; i < sw; i++) begin
      if (!fb[p+i]) e.ferr = 1'b1;
      else          allz   = 1'b0;
    end
    e.brk = e.ferr && allz && (e.data == 0) && !e.par;
    return e;
  endfunction

  task automatic push(input int dut, input exp_t e);
    if (dut == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic drive(input int dut, input logic v, input int n);
    if (dut == 0) rx_a = v;
    else          rx_b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int dut, input logic [8:0] d, input int dw, input logic pb,
                      input logic [1:0] stops, input int sw, input int glitch_bit,
                      input bit chg, input logic [1:0] mid_mode);
    logic [15:0] fb;
    int          n;
    fb = '0;
    n  = 1;
    for (int i = 0; i < dw; i++) begin fb[n] = d[i]; n++; end
    if (mode == 2'b01 || mode == 2'b10) begin fb[n] = pb; n++; end
    for (int i = 0; i < sw; i++) begin fb[n] = stops[i]; n++; end
    push(dut, model(fb, dw, sw, mode));
    for (int i = 0; i < n; i++) begin
      if (chg && i == 4) mode = mid_mode;
      if (i == glitch_bit) begin
        drive(dut, fb[i], 28);
        drive(dut, ~fb[i], 4);
        drive(dut, fb[i], 32);
      end else begin
        drive(dut, fb[i], 64);
      end
    end
    drive(dut, 1'b1, 64);
  endtask

  always @(negedge clk) begin
    exp_t act;
    logic dn, bz;
    for (int k = 0; k < 2; k++) begin
      act = (k == 0) ? {1'b0, a_data, a_par, a_perr, a_ferr, a_brk}
                     : {2'b0, b_data, b_par, b_perr, b_ferr, b_brk};
      dn  = (k == 0) ? a_done : b_done;
      bz  = (k == 0) ? a_busy : b_busy;
      if (!rst_n) begin
        cur[k] = '0;
        if (k == 0) q0.delete();
        else        q1.delete();
        chk($sformatf("reset_quiet_%0d", k), {30'd0, dn, bz}, 32'd0);
      end else if (dn) begin
        if (k == 0) dones_a++;
        else        dones_b++;
        chk($sformatf("done_expected_%0d", k), (k == 0) ? q0.size() : q1.size(), 32'd1);
        if (k == 0 && q0.size() != 0) cur[0] = q0.pop_front();
        if (k == 1 && q1.size() != 0) cur[1] = q1.pop_front();
      end
      chk($sformatf("outputs_%0d", k), act, cur[k]);
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_a", {a_data, a_par, a_perr, a_ferr, a_brk, a_done, a_busy}, 32'd0);
    chk("reset_b", {b_data, b_par, b_perr, b_ferr, b_brk, b_done, b_busy}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    drive(0, 1'b1, 128);

    // 0xEA, even parity, correct parity bit
    send(0, 9'h0EA, 8, 1'b1, 2'b11, 1, -1, 1'b0, 2'b00);
    chk("f1_data", a_data, 32'hEA);
    chk("f1_flags", {a_par, a_perr, a_ferr, a_brk}, 32'b1000);

    // same word, wrong parity bit; mode changed mid-frame must be ignored
    send(0, 9'h0EA, 8, 1'b0, 2'b11, 1, -1, 1'b1, 2'b00);
    mode = 2'b01;
    chk("f2_data", a_data, 32'hEA);
    chk("f2_flags", {a_par, a_perr, a_ferr, a_brk}, 32'b0100);

    // break: line low for two frame times, then re-armed by a high period
    push(0, model(16'h0000, 8, 1, mode));
    drive(0, 1'b0, 22 * 64);
    chk("brk_flags", {a_data, a_perr, a_ferr, a_brk}, 32'b0_0000_0000_011);
    drive(0, 1'b1, 64);
    send(0, 9'h041, 8, 1'b0, 2'b11, 1, -1, 1'b0, 2'b00);
    chk("f3_data", a_data, 32'h41);
    chk("f3_flags", {a_perr, a_ferr, a_brk}, 32'b000);

    // start glitch: 4 ticks low
    drive(0, 1'b0, 16);
    chk("glitch_busy_hi", a_busy, 32'd1);
    drive(0, 1'b1, 64);
    chk("glitch_busy_lo", a_busy, 32'd0);
    chk("glitch_hold", {a_data, a_ferr}, {23'd0, 8'h41, 1'b0});

    // 7 data bits, 2 stops, odd parity, second stop low
    mode = 2'b10;
    send(1, 9'h055, 7, 1'b1, 2'b01, 2, -1, 1'b0, 2'b00);
    chk("b_data", b_data, 32'h55);
    chk("b_flags", {b_par, b_perr, b_ferr, b_brk}, 32'b1010);
    drive(1, 1'b1, 64);

    // reset during data bit 3 of a frame
    mode = 2'b01;
    drive(0, 1'b0, 64);
    drive(0, 1'b1, 3 * 64 + 32);
    chk("pre_reset_busy", a_busy, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_reset_a", {a_data, a_par, a_perr, a_ferr, a_brk, a_done, a_busy}, 32'd0);
    chk("mid_reset_b", {b_data, b_par, b_perr, b_ferr, b_brk, b_done, b_busy}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    drive(0, 1'b1, 128);
`ifdef UART_RX_MAJORITY_EN
    send(0, 9'h03C, 8, 1'b0, 2'b11, 1, 3, 1'b0, 2'b00);
`else
    send(0, 9'h03C, 8, 1'b0, 2'b11, 1, -1, 1'b0, 2'b00);
`endif
    chk("f4_data", a_data, 32'h3C);
    chk("f4_flags", {a_par, a_perr, a_ferr, a_brk}, 32'b0000);

    drive(0, 1'b1, 64);
    chk("queues_drained", q0.size() + q1.size(), 32'd0);
    chk("done_count_a", dones_a, 32'd5);
    chk("done_count_b", dones_b, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
